// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory initiator. Handles one load/store at a time,
//                aligns addresses to whole words, extracts and extends
//                byte/halfword load lanes, and does read-modify-write for
//                sub-word stores. Misaligned or illegal accesses complete
//                with an error and never strobe the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int DW    = 32,
    parameter int ADDRW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_funct3,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DW-1:0]    req_wdata,
    output logic [ADDRW-1:0] mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic             mem_write,
    output logic             mem_read,
    input  logic [DW-1:0]    mem_rdata,
    output logic             resp_valid,
    output logic [DW-1:0]    resp_rdata,
    output logic             resp_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ST_RD = 3'd2,
        S_ST_WR = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADDRW-1:0] r_addr;
    logic [2:0]       r_funct3;
    logic [15:0]      r_wdata;      // only the low half is ever written for B/H
    logic [DW-1:0]    r_merge;
    logic [DW-1:0]    r_resp_rdata;
    logic             r_resp_err;

    logic             w_req_err;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [DW-1:0]    w_load_data;
    logic [DW-1:0]    w_merge;

    // Classify the incoming request: alignment and funct3 legality
    always_comb begin
        w_req_err = 1'b0;
        case (req_funct3)
            c_F3_B:  w_req_err = 1'b0;
            c_F3_H:  w_req_err = req_addr[0];
            c_F3_W:  w_req_err = (req_addr[1:0] != 2'b00);
            c_F3_BU: w_req_err = req_write;
            c_F3_HU: w_req_err = req_write | req_addr[0];
            default: w_req_err = 1'b1;
        endcase
    end

    // Lane extraction and sign/zero extension of the returned memory word
    always_comb begin
        w_byte      = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half      = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_load_data = mem_rdata;
        case (r_funct3)
            c_F3_B:  w_load_data = {{(DW-8){w_byte[7]}}, w_byte};
            c_F3_BU: w_load_data = {{(DW-8){1'b0}}, w_byte};
            c_F3_H:  w_load_data = {{(DW-16){w_half[15]}}, w_half};
            c_F3_HU: w_load_data = {{(DW-16){1'b0}}, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Read-modify-write merge: overwrite the addressed lane(s) of the old word
    always_comb begin
        w_merge = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_nxt = S_RESP;
                    end else if (!req_write) begin
                        w_state_nxt = S_LOAD;
                    end else if (req_funct3 == c_F3_W) begin
                        w_state_nxt = S_ST_WR;
                    end else begin
                        w_state_nxt = S_ST_RD;
                    end
                end
            end
            S_LOAD:  w_state_nxt = S_RESP;
            S_ST_RD: w_state_nxt = S_ST_WR;
            S_ST_WR: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory-side and handshake outputs; reset masks every strobe immediately
    always_comb begin
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (r_state != S_IDLE) begin
            mem_addr = {r_addr[ADDRW-1:2], 2'b00};
        end
        if (!rst) begin
            case (r_state)
                S_IDLE:  req_ready  = 1'b1;
                S_LOAD:  mem_read   = 1'b1;
                S_ST_RD: mem_read   = 1'b1;
                S_ST_WR: begin
                    mem_write = 1'b1;
                    mem_wdata = r_merge;
                end
                S_RESP:  resp_valid = 1'b1;
                default: req_ready  = 1'b0;
            endcase
        end
    end

    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    // State, request latch, merge word and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_wdata      <= '0;
            r_merge      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata[15:0];
                        if (w_req_err) begin
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                        end else if (req_write && (req_funct3 == c_F3_W)) begin
                            r_merge <= req_wdata;
                        end
                    end
                end
                S_LOAD: begin
                    r_resp_rdata <= w_load_data;
                    r_resp_err   <= 1'b0;
                end
                S_ST_RD: begin
                    r_merge <= w_merge;
                end
                S_ST_WR: begin
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                end
                default: begin
                    r_resp_err <= r_resp_err;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit with a word memory
//                and an arithmetic reference model of loads/stores/errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    always #5 clk = ~clk;

    load_store_unit #(.DW(32), .ADDRW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // Memory: combinational read, write at the clock edge
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if (wr && (f3 == 4 || f3 == 5)) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 2 && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input int off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b ^ 32'h80) - 32'h80;
            3'd4: return b;
            3'd1: return (h ^ 32'h8000) - 32'h8000;
            3'd5: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                              input int off, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (f3 == 2) return wd;
        mask = (f3 == 0) ? 32'hFF : 32'hFFFF;
        sh   = (f3 == 0) ? 8 * off : 16 * (off / 2);
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    // One transaction: accept, watch strobes, check response against the model
    task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got);
        logic        e;
        int          idx, off, exp_lat, exp_rd, exp_wr;
        int          lat, rd, wrc, proto;
        logic [31:0] exp_rdata;
        string       t;
        e   = ref_err(wr, f3, a);
        idx = (a % 256) / 4;
        off = a % 4;
        exp_rd    = (!e && (!wr || f3 != 2)) ? 1 : 0;
        exp_wr    = (!e && wr) ? 1 : 0;
        exp_lat   = e ? 1 : (wr && f3 != 2) ? 3 : 2;
        exp_rdata = (!e && !wr) ? ref_load(ref_mem[idx], f3, off) : 32'h0;
        t = $sformatf("%s f3=%0d @%h", wr ? "st" : "ld", f3, a);

        @(negedge clk);
        check({t, " ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0; rd = 0; wrc = 0; proto = 0;
        for (int k = 1; k <= 6; k++) begin
            if (mem_read) rd++;
            if (mem_write) wrc++;
            if (mem_read && mem_write) proto++;
            if ((mem_read || mem_write) && mem_addr !== (a & 32'hFFFF_FFFC)) proto++;
            if (!mem_write && mem_wdata !== 32'h0) proto++;
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({t, " latency"}, lat, exp_lat);
        check({t, " reads"}, rd, exp_rd);
        check({t, " writes"}, wrc, exp_wr);
        check({t, " protocol"}, proto, 0);
        check({t, " err"}, {31'b0, resp_err}, {31'b0, e});
        check({t, " rdata"}, resp_rdata, exp_rdata);
        if (wr && !e) begin
            ref_mem[idx] = ref_store(ref_mem[idx], f3, off, wd);
            check({t, " memword"}, mem[idx], ref_mem[idx]);
        end
        got = resp_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int acc, rsp, bad, viol;
        logic        w;
        logic [2:0]  f;
        logic [31:0] a;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;

        // Preload memory while in reset
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_idx = 6'(i);
            pl_data = (i == 4) ? 32'h8844_22F1 : (i == 8) ? 32'h1122_3344 : $urandom;
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en = 1'b0;
        #1;
        check("rst mem_read", {31'b0, mem_read}, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst req_ready", {31'b0, req_ready}, 32'd1);
        check("post-rst resp_rdata", resp_rdata, 32'h0);
        check("post-rst resp_err", {31'b0, resp_err}, 32'd0);
        check("post-rst mem_addr", mem_addr, 32'h0);
        check("post-rst mem_wdata", mem_wdata, 32'h0);

        // Loads from word 0x10
        do_txn(1'b0, 3'd0, 32'h10, 32'h0, got); check("LB const", got, 32'hFFFF_FFF1);
        do_txn(1'b0, 3'd4, 32'h10, 32'h0, got); check("LBU const", got, 32'h0000_00F1);
        do_txn(1'b0, 3'd1, 32'h12, 32'h0, got); check("LH const", got, 32'hFFFF_8844);
        do_txn(1'b0, 3'd5, 32'h12, 32'h0, got); check("LHU const", got, 32'h0000_8844);
        do_txn(1'b0, 3'd2, 32'h10, 32'h0, got); check("LW const", got, 32'h8844_22F1);

        // Sub-word stores into 0x20
        do_txn(1'b1, 3'd0, 32'h21, 32'h0000_00AB, got);
        check("SB word const", mem[8], 32'h1122_AB44);
        do_txn(1'b1, 3'd1, 32'h22, 32'h0000_BEEF, got);
        check("SH word const", mem[8], 32'hBEEF_AB44);

        // Word store then read back
        do_txn(1'b1, 3'd2, 32'h30, 32'hDEAD_BEEF, got);
        do_txn(1'b0, 3'd2, 32'h30, 32'h0, got); check("LW after SW", got, 32'hDEAD_BEEF);

        // Error cases
        do_txn(1'b0, 3'd2, 32'h31, 32'h0, got);
        do_txn(1'b1, 3'd1, 32'h23, 32'h1234, got);
        do_txn(1'b0, 3'd3, 32'h10, 32'h0, got);
        do_txn(1'b1, 3'd4, 32'h20, 32'h77, got);

        // Reset during the write phase of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmw read phase", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        check("rmw write phase", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst masks mem_write", {31'b0, mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("int store word", mem[8], 32'hBEEF_AB44);
        check("int req_ready", {31'b0, req_ready}, 32'd1);
        check("int resp_valid", {31'b0, resp_valid}, 32'd0);
        check("int resp_rdata", resp_rdata, 32'h0);
        check("int mem_addr", mem_addr, 32'h0);
        do_txn(1'b0, 3'd2, 32'h20, 32'h0, got); check("LW after int", got, 32'hBEEF_AB44);

        // Held req_valid stream of loads
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        acc = 0; rsp = 0; bad = 0; viol = 0;
        for (int k = 0; k < 15; k++) begin
            if (req_ready && req_valid) acc++;
            if (resp_valid) begin
                rsp++;
                if (resp_rdata !== ref_mem[4]) bad++;
            end
            if (req_ready && (resp_valid || mem_read || mem_write)) viol++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (resp_valid) rsp++;
            @(negedge clk);
        end
        check("stream accepts", acc, 5);
        check("stream responses", rsp, 5);
        check("stream data", bad, 0);
        check("stream ready busy", viol, 0);

        // Randomized traffic, mostly legal
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (f == 2) a = a & 32'hFC;
                else if (f == 1 || f == 5) a = a & 32'hFE;
            end
            do_txn(w, f, a, $urandom, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
